// File: rtl/seq101_tx.sv
// Serial "101"-sync frame transmitter: sync marker, then a bit-stuffed MSB-first payload,
// then a forced idle gap, so a "101" detector on the line fires exactly once per frame.
module seq101_tx #(
   parameter int W       = 8,
   parameter int MIN_GAP = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out,
   output logic         sof,
   output logic         busy,
   output logic [2:0]   state_dbg
);

   localparam int IDXW = (W > 1) ? $clog2(W) : 1;
   localparam int GAPW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      DATA  = 3'd2,
      STUFF = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t          state;
   logic [1:0]      sync_cnt;
   logic [IDXW-1:0] bit_idx;
   logic [GAPW-1:0] gap_cnt;
   logic [W-1:0]    shreg;
   logic            prev_bit;
   logic [IDXW-1:0] next_idx;
   logic            last_bit;

   // Handshake: a word is accepted on any rising edge where in_valid && in_ready.
   assign in_ready  = (state == IDLE);
   assign state_dbg = state;
   assign next_idx  = bit_idx - 1'b1;
   assign last_bit  = (bit_idx == '0);

   // state names the bit currently on the line; prev_bit is the line bit before it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         sync_cnt <= '0;
         bit_idx  <= '0;
         gap_cnt  <= '0;
         shreg    <= '0;
         prev_bit <= 1'b0;
         out      <= 1'b0;
         sof      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         prev_bit <= out;
         sof      <= 1'b0;
         case (state)
            IDLE: begin
               out  <= 1'b0;
               busy <= 1'b0;
               if (in_valid) begin
                  shreg    <= in_data;
                  sync_cnt <= '0;
                  state    <= SYNC;
                  out      <= 1'b1;
                  sof      <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            SYNC: begin
               sync_cnt <= sync_cnt + 2'd1;
               if (sync_cnt == 2'd0) begin
                  out <= 1'b0;
               end else if (sync_cnt == 2'd1) begin
                  out <= 1'b1;
               end else begin
                  state   <= DATA;
                  bit_idx <= IDXW'(W - 1);
                  out     <= shreg[W-1];
               end
            end
            DATA: begin
               // A payload 0 right after a 1 would open a "101"; pad it with a 0.
               if (!out && prev_bit) begin
                  state <= STUFF;
                  out   <= 1'b0;
               end else if (last_bit) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                  out     <= 1'b0;
               end else begin
                  bit_idx <= next_idx;
                  out     <= shreg[next_idx];
               end
            end
            STUFF: begin
               if (last_bit) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                  out     <= 1'b0;
               end else begin
                  state   <= DATA;
                  bit_idx <= next_idx;
                  out     <= shreg[next_idx];
               end
            end
            GAP: begin
               out <= 1'b0;
               if (gap_cnt == GAPW'(MIN_GAP - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               out   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq101_tx.sv
// Bench for seq101_tx: directed W=4 frames plus a cycle-accurate scoreboard on a W=8,
// MIN_GAP=2 instance with line detector, de-stuffer, spacing and reset checks.
module tb_seq101_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;

   logic       a_valid, a_ready, a_out, a_sof, a_busy;
   logic [3:0] a_data;
   logic [2:0] a_state;

   logic       b_valid, b_ready, b_out, b_sof, b_busy;
   logic [7:0] b_data;
   logic [2:0] b_state;

   seq101_tx #(.W(4), .MIN_GAP(1)) u_dut_a (
      .clk(clk), .resetn(resetn), .in_valid(a_valid), .in_data(a_data),
      .in_ready(a_ready), .out(a_out), .sof(a_sof), .busy(a_busy), .state_dbg(a_state)
   );

   seq101_tx #(.W(8), .MIN_GAP(2)) u_dut_b (
      .clk(clk), .resetn(resetn), .in_valid(b_valid), .in_data(b_data),
      .in_ready(b_ready), .out(b_out), .sof(b_sof), .busy(b_busy), .state_dbg(b_state)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard for instance b: {out, sof, busy} per cycle
   logic [2:0] exp_q[$];
   logic [7:0] acc_q[$];
   logic       sb_on  = 1'b0;
   logic       mon_on = 1'b0;
   int         cyc = 0;
   int         pend_len = 0, prev_len = 0, last_sof = -1, dets = 0;
   logic [2:0] win = 3'b000;
   logic       b_have;
   logic [2:0] b_exp;
   int         ds_pos = 0, ds_n = 0;
   logic       ds_act = 1'b0, ds_skip = 1'b0, ds_prev = 1'b0;
   logic [7:0] ds_word = 8'h00;

   task automatic push_frame(input logic [7:0] d);
      int  n;
      logic p;
      n = 0;
      exp_q.push_back(3'b111);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b101);
      p = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         exp_q.push_back({d[i], 1'b0, 1'b1});
         n++;
         if (!d[i] && p) begin
            exp_q.push_back(3'b001);
            n++;
            p = 1'b0;
         end else begin
            p = d[i];
         end
      end
      for (int g = 0; g < 2; g++) exp_q.push_back(3'b001);
      pend_len = 3 + n;
      if (mon_on) acc_q.push_back(d);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (sb_on) begin
         b_have = (exp_q.size() > 0);
         b_exp  = b_have ? exp_q.pop_front() : 3'b000;
         check("b_out",   b_out,   b_exp[2]);
         check("b_sof",   b_sof,   b_exp[1]);
         check("b_busy",  b_busy,  b_exp[0]);
         check("b_ready", b_ready, !b_have);
         if (mon_on) begin
            if (b_sof) begin
               if (last_sof >= 0) begin
                  check("b_spacing", cyc - last_sof, prev_len + 3);
                  check("det_once", dets, 1);
               end
               last_sof = cyc;
               prev_len = pend_len;
               dets     = 0;
               ds_act = 1'b1; ds_pos = 0; ds_n = 0; ds_skip = 1'b0; ds_prev = 1'b1;
            end else if (ds_act) begin
               ds_pos++;
               if (ds_pos >= 3) begin
                  if (ds_skip) begin
                     ds_skip = 1'b0;
                     ds_prev = 1'b0;
                  end else begin
                     ds_word = {ds_word[6:0], b_out};
                     ds_skip = !b_out && ds_prev;
                     ds_prev = b_out;
                     ds_n++;
                     if (ds_n == 8) begin
                        ds_act = 1'b0;
                        if (acc_q.size() == 0) check("destuff_q", 1, 0);
                        else check("destuff", ds_word, acc_q.pop_front());
                     end
                  end
               end
            end
            win = {win[1:0], b_out};
            if (win == 3'b101) begin
               dets++;
               check("det_pos", cyc - last_sof, 2);
            end
         end
         if (!resetn) exp_q.delete();
         else if (!b_have && b_valid) push_frame(b_data);
      end
   end

   // ---------------- directed W=4 frames on instance a: {out, sof, busy, ready}
   logic [3:0] a_q[$];

   task automatic run4(input logic [3:0] d, input logic [15:0] bits, input int n);
      logic [3:0] e;
      logic [2:0] w;
      int         hits;
      for (int i = 0; i < 50 && !a_ready; i++) begin
         @(posedge clk); #1;
      end
      check("a_ready_pre", a_ready, 1);
      a_valid = 1'b1;
      a_data  = d;
      @(posedge clk); #1;
      a_valid = 1'b0;
      a_data  = 4'($urandom);
      for (int i = 0; i < n; i++) a_q.push_back({bits[n-1-i], (i == 0), 1'b1, 1'b0});
      a_q.push_back(4'b0010);
      a_q.push_back(4'b0001);
      w = 3'b000;
      hits = 0;
      while (a_q.size() > 0) begin
         @(negedge clk);
         e = a_q.pop_front();
         check("a_out",   a_out,   e[3]);
         check("a_sof",   a_sof,   e[2]);
         check("a_busy",  a_busy,  e[1]);
         check("a_ready", a_ready, e[0]);
         w = {w[1:0], a_out};
         if (w == 3'b101) hits++;
         @(posedge clk); #1;
      end
      check("a_det_once", hits, 1);
   endtask

   task automatic wait_b_idle(input string tag);
      int i;
      i = 0;
      while (!b_ready && i < 80) begin
         @(posedge clk); #1;
         i++;
      end
      check(tag, b_ready, 1);
   endtask

   initial begin
      resetn  = 1'b0;
      a_valid = 1'b0; a_data = '0;
      b_valid = 1'b0; b_data = '0;
      repeat (3) @(posedge clk);
      #1;
      sb_on = 1'b1;
      @(negedge clk);
      check("rst_a_out",  a_out,  0);
      check("rst_a_sof",  a_sof,  0);
      check("rst_a_busy", a_busy, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      check("rel_a_ready", a_ready, 1);
      @(posedge clk); #1;

      run4(4'b0110, 16'b101001100, 9);
      run4(4'b1010, 16'b101100100, 9);
      run4(4'b0000, 16'b10100000,  8);
      run4(4'b1111, 16'b1011111,   7);

      // continuous valid with fresh random data every cycle
      acc_q.delete();
      last_sof = -1;
      win = 3'b000;
      mon_on = 1'b1;
      b_valid = 1'b1;
      for (int i = 0; i < 130; i++) begin
         b_data = 8'($urandom);
         @(posedge clk); #1;
      end
      b_valid = 1'b0;
      wait_b_idle("b_idle_stream");
      repeat (2) @(posedge clk);
      #1;
      mon_on = 1'b0;
      check("acc_q_empty", acc_q.size(), 0);

      // reset in the 5th cycle of a frame
      b_valid = 1'b1; b_data = 8'hA5;
      @(posedge clk); #1;
      b_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      resetn = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_out",  b_out,  0);
      check("abort_busy", b_busy, 0);
      check("abort_sof",  b_sof,  0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      check("abort_ready", b_ready, 1);
      @(posedge clk); #1;
      b_valid = 1'b1; b_data = 8'h3C;
      @(posedge clk); #1;
      b_valid = 1'b0;
      wait_b_idle("b_idle_after_abort");

      // valid pulsed while busy must be ignored
      b_valid = 1'b1; b_data = 8'h81;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         b_valid = 1'($urandom_range(0, 1));
         b_data  = 8'($urandom);
         @(negedge clk);
         check("busy_no_ready", b_ready, 0);
         @(posedge clk); #1;
      end
      b_valid = 1'b0;
      wait_b_idle("b_idle_after_pulse");

      // random valid/data/reset soak
      for (int i = 0; i < 200; i++) begin
         resetn  = ($urandom_range(0, 31) != 0);
         b_valid = 1'($urandom_range(0, 1));
         b_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      resetn  = 1'b1;
      b_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("exp_q_drained", exp_q.size(), 0);
      sb_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq101_tx.md
Name: seq101_tx

Overview:
- Serial frame transmitter producing the bit stream consumed by the team's "101" sequence-detector FSMs.
- Accepts a W-bit payload word over a valid/ready handshake.
- Emits, one bit per clock, a "101" sync marker followed by the payload MSB-first.
- Bit-stuffs the payload so "101" never appears anywhere in the frame except the sync marker. A detector on the line therefore asserts exactly once per frame.

Parameters:
W, 8, payload width in bits (W >= 1)
MIN_GAP, 1, idle cycles (out=0) forced after each frame before the next one is accepted (MIN_GAP >= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset
in_valid  input  1  payload word available
in_data  input  W  payload word; sampled on accept
in_ready  output  1  block can accept a word; combinational, equals (state==IDLE)
out  output  1  serial line bit; registered (Moore)
sof  output  1  high during the cycle carrying the first sync bit
busy  output  1  high from the first sync cycle through the last gap cycle

Behaviour:
- Reset:
  - resetn low at a rising edge -> state IDLE; out=0, sof=0, busy=0; shift register and counters cleared.
  - in_ready=1 in the cycle after reset releases.
  - Reset mid-frame aborts the frame immediately. No stuff or gap bits are emitted. The line shows out=0 from the next cycle.
- Accept: in_valid && in_ready at rising edge k.
  - in_data is latched.
  - Cycle k+1 carries the first sync bit: out=1, sof=1, busy=1.
  - in_valid while not ready is ignored; in_data is not required to be held.
- States: IDLE, SYNC, DATA, STUFF, GAP.
  - IDLE: out=0, busy=0, in_ready=1. On accept -> SYNC.
  - SYNC: 3 cycles with out = 1, 0, 1. After the third cycle -> DATA.
  - DATA: one cycle per payload bit, MSB first.
    - If the bit just emitted is 0 and the previously emitted line bit was 1 -> STUFF.
    - This includes the sync's final 1 preceding payload bit W-1.
    - Otherwise continue to the next bit, or -> GAP after bit 0.
  - STUFF: one cycle, out=0. Then -> DATA (next bit), or -> GAP if the stuffed bit followed payload bit 0. The stuff rule applies to the last payload bit too.
  - GAP: MIN_GAP cycles with out=0, busy=1, in_ready=0. Then -> IDLE.
- Stuff history:
  - The previous-bit register tracks emitted line bits.
  - A stuffed 0 and the sync's middle 0 never trigger stuffing; only payload 0 bits do.
- Frame length: 3 + W + (number of payload "10" transitions, counting the sync-1 to first-bit boundary).
  - Maximum is 3 + W + ceil(W/2).
  - Counters must be sized for this.
- Back-to-back frames:
  - Minimum frame spacing is frame length + MIN_GAP + 1 (IDLE accept cycle).
  - in_ready is never asserted during a frame or gap.
- Guarantee: within any frame plus its gap, the only "101" window is the sync marker.

Test Plan:
- W=4, MIN_GAP=1, accept 4'b0110 -> out from k+1: 1 0 1 0 0 1 1 0 0, then 0 (gap); sof high on the first cycle only; busy high for 10 cycles; in_ready back to 1 after the gap.
- W=4, data 4'b1010 -> out: 1 0 1 1 0 0 1 0 0, then gap 0; detector model asserts exactly once.
- W=4, data 4'b0000 -> out: 1 0 1 0 0 0 0 0 (single stuff after the first payload bit); data 4'b1111 -> 1 0 1 1 1 1 1 (no stuff).
- in_valid held high continuously with random data, W=8, MIN_GAP=2 -> each frame starts exactly frame-length+3 cycles after the previous; a reference "101" detector fires once per frame at sync bit 3; de-stuffed payload equals the input.
- Reset low at the 5th cycle of a frame -> out=0, busy=0, sof=0 the next cycle; in_ready=1 after release; the next accepted frame is correct.
- in_valid pulsed while busy -> no accept, no data change; 200 cycles of random valid/data/resetn (reset ~1/32) -> stream matches the behavioural model every cycle.
